rr_onehot_arbiter: RTL
======================

Name: rr_onehot_arbiter

Overview:
- Round-robin arbiter that shares one downstream consumer among 8 requesters (e.g. writeback/result bus, shared shifter/ALU port).
- Picks one valid requester per cycle and drives the one-hot select of an 8-way one-hot mux for the payload.
- Registers the winning payload into a single-entry output buffer with valid/ready handshake.
- Sustains 1 transfer/cycle when downstream is ready.

Parameters:
- WIDTH, 32, payload width in bits.

Ports:
- clk  input  1  clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  8  per-requester valid
- in_data  input  8*WIDTH  packed payloads; requester i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  8  per-requester accept; at most one bit set
- req_mask  input  8  1 = requester eligible; masked requesters are never granted
- out_valid  output  1  output buffer holds a payload
- out_data  output  WIDTH  buffered payload
- out_src  output  3  index of the requester that supplied out_data
- out_grant  output  8  one-hot form of out_src; 0 when out_valid=0
- out_ready  input  1  downstream accept

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_src=0, out_grant=0, ptr=0. in_ready is combinational and is 0 while rst_n=0.
- Eligibility: elig = in_valid & req_mask.
- Buffer-accept condition: can_load = !out_valid | out_ready.
- Pick (combinational): first set bit of elig, scanning ptr, ptr+1, ..., ptr+7 (mod 8). pick_oh is the one-hot result; 0 if elig=0.
- in_ready = can_load ? pick_oh : 8'b0.
  - in_ready depends on in_valid. Requesters must not make in_valid depend on in_ready.
- Transfer from requester i: in_valid[i] & in_ready[i].
- On a transfer at clock edge:
  - out_data <= payload selected by pick_oh; out_src <= index; out_grant <= pick_oh; out_valid <= 1.
  - ptr <= (index+1) mod 8; wrap 7 -> 0.
- Output handshake: a beat leaves when out_valid & out_ready.
  - If it leaves and no transfer happens that cycle: out_valid <= 0, out_grant <= 0, out_data and out_src hold their values.
- Simultaneous dequeue and transfer: buffer reloads in the same cycle. out_valid stays 1, giving back-to-back beats with no bubble.
- Stall (out_valid=1 & out_ready=0):
  - in_ready = 0.
  - out_data, out_src, out_grant and ptr hold.
  - Output is stable until accepted.
- ptr changes only on a transfer. Idle cycles and masked requesters do not move it.
- Fairness: with all 8 continuously eligible and out_ready=1, grants cycle 0,1,...,7,0. No requester waits more than 7 transfers.
- Mask changes take effect on the same-cycle pick. A buffered beat from a now-masked requester is still delivered.
- Latency: input accept -> out_valid is 1 cycle. Throughput is 1 beat/cycle.
- Reset mid-operation: the buffered beat is discarded, ptr returns to 0, no in_ready is asserted during reset.
- Internal states (derived from out_valid):
  - EMPTY: out_valid=0. Goes to FULL on a transfer.
  - FULL: out_valid=1.
    - Goes to EMPTY on dequeue with no transfer.
    - Stays FULL on a stall, or on dequeue+transfer.

Decomposition:
- Shared package:
  - N_REQ = 8
  - idx_t: logic [2:0]
  - oh_t: logic [7:0]
  - functions oh_to_idx and idx_to_oh
- Sub-module rr_pick: combinational, inputs elig and ptr, output pick_oh.
  - Implemented as double-width rotate-and-priority-encode.
- Payload selection reuses the existing 8-input one-hot mux with sel = pick_oh.
  - The mux default (sel=0 -> in0) is harmless because no load occurs when pick_oh=0.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_grant=0, in_ready=0 immediately; after release, first pick starts at requester 0.
- Fairness: all in_valid=8'hFF, req_mask=8'hFF, out_ready=1, payload i = 32'hA0+i for 16 cycles -> out_src sequence 0..7,0..7, out_data 32'hA0..A7 repeated, out_valid continuously 1 from cycle 1.
- Pointer wrap/skip: only requesters 2 and 6 valid, ptr=7 after grant of 6 -> next grant 2, then 6, then 2; in_ready one-hot each cycle.
- Backpressure: buffer holds requester 3 beat 32'hDEAD, out_ready=0 for 5 cycles with requesters 3,4 valid -> in_ready=0, out_data=32'hDEAD, out_grant=8'h08 stable; out_ready=1 -> next beat from 4.
- Masking: in_valid=8'hFF, req_mask=8'h11 -> grants alternate 0,4; change mask to 8'h80 -> next grant 7, and ptr then wraps to 0.
- Idle/bubble: single request on requester 5 for one cycle, out_ready=1 -> exactly one out_valid pulse with out_src=5, out_grant=8'h20; then out_valid=0, out_grant=0, ptr=6 retained.

Source files
------------

// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared types and helpers for the 8-requester round-robin one-hot arbiter.
package rr_onehot_arbiter_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [N_REQ-1:0] oh_t;

  // Output buffer occupancy; mirrors out_valid.
  typedef enum logic {StEmpty, StFull} state_e;

  function automatic idx_t oh_to_idx(oh_t oh);
    idx_t idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx |= idx_t'(i);
    end
    return idx;
  endfunction

  function automatic oh_t idx_to_oh(idx_t idx);
    return oh_t'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_onehot_arbiter_if.sv
// Request-side and output-side handshake bundle of the round-robin arbiter.
interface rr_onehot_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  import rr_onehot_arbiter_pkg::*;

  oh_t                    in_valid;
  logic [N_REQ*WIDTH-1:0] in_data;
  oh_t                    in_ready;
  oh_t                    req_mask;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  idx_t                   out_src;
  oh_t                    out_grant;
  logic                   out_ready;

  modport master (
    output in_valid, in_data, req_mask, out_ready,
    input  in_ready, out_valid, out_data, out_src, out_grant
  );

  modport slave (
    input  in_valid, in_data, req_mask, out_ready,
    output in_ready, out_valid, out_data, out_src, out_grant
  );

endinterface

// File: rtl/rr_onehot_arbiter_rr_pick.sv
// Round-robin pick: rotate eligibility so ptr sits at bit 0, priority-encode, rotate back.
module rr_onehot_arbiter_rr_pick
  import rr_onehot_arbiter_pkg::*;
(
  input  oh_t  i_elig,
  input  idx_t i_ptr,
  output oh_t  o_pick_oh
);

  oh_t  w_rot;
  idx_t w_off;
  idx_t w_idx;
  logic w_found;

  // Bit k of w_rot is requester (ptr + k) mod 8.
  assign w_rot = oh_t'({i_elig, i_elig} >> i_ptr);

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = idx_t'(k);
      end
    end
  end

  assign w_idx     = i_ptr + w_off;
  assign o_pick_oh = w_found ? idx_to_oh(w_idx) : '0;

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter: 8 requesters share one single-entry output buffer with valid/ready.
module rr_onehot_arbiter
  import rr_onehot_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic                clk,
  input logic                rst_n,
  rr_onehot_arbiter_if.slave bus
);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_data;
  idx_t             r_src;
  oh_t              r_grant;
  idx_t             r_ptr;

  oh_t              w_elig;
  oh_t              w_pick_oh;
  idx_t             w_pick_idx;
  oh_t              w_in_ready;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_out_valid;
  logic             w_can_load;
  logic             w_load;
  logic             w_deq;

  assign w_elig = bus.in_valid & bus.req_mask;

  rr_onehot_arbiter_rr_pick u_pick (
    .i_elig    (w_elig),
    .i_ptr     (r_ptr),
    .o_pick_oh (w_pick_oh)
  );

  assign w_pick_idx = oh_to_idx(w_pick_oh);

  // One-hot payload mux; sel=0 falls back to requester 0 but never loads.
  always_comb begin
    w_sel_data = bus.in_data[WIDTH-1:0];
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick_oh[i]) w_sel_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StEmpty: if (w_load) w_state_next = StFull;
      StFull:  if (bus.out_ready && !w_load) w_state_next = StEmpty;
    endcase
  end

  always_comb begin
    w_out_valid = (r_state == StFull);
    w_can_load  = !w_out_valid || bus.out_ready;
    // Gated by rst_n so no requester is accepted while reset is held.
    w_in_ready  = (rst_n && w_can_load) ? w_pick_oh : '0;
    w_load      = |w_in_ready;
    w_deq       = w_out_valid && bus.out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_src   <= '0;
      r_grant <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      r_data  <= w_sel_data;
      r_src   <= w_pick_idx;
      r_grant <= w_pick_oh;
      r_ptr   <= w_pick_idx + 3'd1;
    end else if (w_deq) begin
      r_grant <= '0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_data;
  assign bus.out_src   = r_src;
  assign bus.out_grant = r_grant;

endmodule
